// File: rtl/common_pkg.sv
// Shared types for the data-memory path: identifies which requester owns an in-flight read.
package common_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CORE = 2'd1,
      LD   = 2'd2
   } dmem_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-way data-memory arbiter (core vs loader) with starvation guard; grant is same-cycle, read data returns one cycle later.
// Denied requesters see core_stall / !ld_gnt and must hold their request; nothing is queued here.
module dmem_arbiter
   import common_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_stall,
   output logic [31:0]       core_rdata,
   output logic              core_rvalid,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_gnt,
   output logic [31:0]       ld_rdata,
   output logic              ld_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0]  ld_wait_cnt;
   logic              starve;
   logic              core_gnt;
   dmem_owner_t       rd_owner;
   dmem_owner_t       rd_owner_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       core_rdata_q;
   logic [31:0]       ld_rdata_q;

   // Grant and memory drive; nothing is granted while reset is held.
   always_comb begin
      starve       = (ld_wait_cnt == CNT_W'(STARVE_MAX));
      core_gnt     = 1'b0;
      ld_gnt       = 1'b0;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      mem_we       = 1'b0;
      rd_owner_nxt = NONE;
      if (!rst) begin
         core_gnt = core_req && !(ld_req && starve);
         ld_gnt   = ld_req && !core_gnt;
      end
      if (core_gnt) begin
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_we    = core_we;
         if (!core_we) rd_owner_nxt = CORE;
      end else if (ld_gnt) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
         mem_we    = ld_we;
         if (!ld_we) rd_owner_nxt = LD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_owner     <= NONE;
         ld_wait_cnt  <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         ld_rdata_q   <= '0;
      end else begin
         rd_owner <= rd_owner_nxt;
         if (core_gnt || ld_gnt) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end
         if (ld_req && !ld_gnt) begin
            if (!starve) ld_wait_cnt <= ld_wait_cnt + 1'b1;
         end else begin
            ld_wait_cnt <= '0;
         end
         // Keep the returned word so a non-owner's rdata stays put.
         if (rd_owner == CORE) core_rdata_q <= mem_rdata;
         if (rd_owner == LD)   ld_rdata_q   <= mem_rdata;
      end
   end

   assign core_stall  = core_req && !core_gnt;
   assign core_rvalid = (rd_owner == CORE);
   assign ld_rvalid   = (rd_owner == LD);
   assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
   assign ld_rdata    = ld_rvalid   ? mem_rdata : ld_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for arbitration plus read-return scoreboard, with contention, idle and reset-mid-read sequences.
module tb_dmem_arbiter;
   import common_pkg::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req, core_we;
   logic [AW-1:0] core_addr;
   logic [31:0]   core_wdata;
   logic          core_stall;
   logic [31:0]   core_rdata;
   logic          core_rvalid;
   logic          ld_req, ld_we;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_wdata;
   logic          ld_gnt;
   logic [31:0]   ld_rdata;
   logic          ld_rvalid;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Data memory: synchronous write, registered read (one cycle latency), plus a preload port.
   logic [31:0] mem_arr [256];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [31:0] pl_dat = '0;
   always @(posedge clk) begin
      if (pl_we) mem_arr[pl_addr] <= pl_dat;
      else if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= mem_arr[mem_addr[9:2]];
   end

   typedef struct {
      logic          creq, cwe;
      logic [AW-1:0] caddr;
      logic [31:0]   cwd;
      logic          lreq, lwe;
      logic [AW-1:0] laddr;
      logic [31:0]   lwd;
      logic          stall, lgnt;
   } vec_t;

   typedef struct {
      dmem_owner_t own;
      logic [31:0] dat;
   } exp_t;

   exp_t          exp_q[$];
   logic [31:0]   ref_mem [256];
   logic [AW-1:0] last_addr;
   logic [31:0]   last_wdata;
   logic [31:0]   exp_core_rdata, exp_ld_rdata;
   int            n_checks = 0;
   int            n_fail   = 0;
   vec_t          vecs[13];

   function automatic vec_t mk(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                               input logic [31:0] cwd, input logic lreq, input logic lwe,
                               input logic [AW-1:0] laddr, input logic [31:0] lwd,
                               input logic st, input logic lg);
      vec_t v;
      v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.lreq = lreq; v.lwe = lwe; v.laddr = laddr; v.lwd = lwd;
      v.stall = st;  v.lgnt = lg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Read-return side: at most one expected return per cycle, due exactly one cycle after issue.
   task automatic check_resp();
      exp_t e;
      e.own = NONE;
      e.dat = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("core_rvalid", 32'(core_rvalid), 32'(e.own == CORE));
      check("ld_rvalid", 32'(ld_rvalid), 32'(e.own == LD));
      if (e.own == CORE) exp_core_rdata = e.dat;
      if (e.own == LD)   exp_ld_rdata   = e.dat;
      check("core_rdata", core_rdata, exp_core_rdata);
      check("ld_rdata", ld_rdata, exp_ld_rdata);
   endtask

   task automatic drive_idle();
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic apply(input vec_t v);
      logic          cg;
      logic          ewe;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      exp_t          e;
      @(posedge clk); #1;
      core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
      ld_req = v.lreq; ld_we = v.lwe; ld_addr = v.laddr; ld_wdata = v.lwd;
      @(negedge clk);
      check_resp();
      check("core_stall", 32'(core_stall), 32'(v.stall));
      check("ld_gnt", 32'(ld_gnt), 32'(v.lgnt));
      cg  = v.creq && !v.stall;
      ea  = last_addr;
      ed  = last_wdata;
      ewe = 1'b0;
      if (cg) begin
         ea = v.caddr; ed = v.cwd; ewe = v.cwe;
      end else if (v.lgnt) begin
         ea = v.laddr; ed = v.lwd; ewe = v.lwe;
      end
      check("mem_we", 32'(mem_we), 32'(ewe));
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ed);
      if (cg || v.lgnt) begin
         last_addr  = ea;
         last_wdata = ed;
         if (ewe) ref_mem[ea[9:2]] = ed;
         else begin
            e.own = cg ? CORE : LD;
            e.dat = ref_mem[ea[9:2]];
            exp_q.push_back(e);
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1);
      vecs[2]  = mk(1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h4,  32'h0,        1'b0, 1'b1);
      vecs[5]  = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0);
      vecs[6]  = mk(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, 1'b1, 32'h34, 32'h0BADF00D, 1'b0, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h34, 32'h0BADF00D, 1'b0, 1'b1);
      vecs[8]  = mk(1'b1, 1'b0, 32'h30, 32'h0,        1'b1, 1'b0, 32'h34, 32'h0,        1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h34, 32'h0,        1'b0, 1'b1);
      vecs[10] = mk(1'b1, 1'b0, 32'h34, 32'h0,        1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 1'b1);
      vecs[12] = mk(1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0);

      ref_mem[4] = 32'hDEADBEEF;
      ref_mem[0] = 32'hAAAA0000;
      ref_mem[1] = 32'hBBBB0004;
      last_addr = '0; last_wdata = '0; exp_core_rdata = '0; exp_ld_rdata = '0;

      // Reset with both requesters asserted: nothing may be granted.
      rst = 1'b1;
      drive_idle();
      core_req = 1'b1; ld_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         pl_we = 1'b1;
         pl_addr = (i == 0) ? 8'd4 : (i == 1) ? 8'd0 : 8'd1;
         pl_dat  = ref_mem[pl_addr];
      end
      @(posedge clk); #1;
      pl_we = 1'b0;
      @(negedge clk);
      check("rst core_stall", 32'(core_stall), 32'd1);
      check("rst ld_gnt", 32'(ld_gnt), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_wdata", mem_wdata, 32'd0);
      check("rst core_rvalid", 32'(core_rvalid), 32'd0);
      check("rst ld_rvalid", 32'(ld_rvalid), 32'd0);
      check("rst core_rdata", core_rdata, 32'd0);
      check("rst ld_rdata", ld_rdata, 32'd0);
      check("rst ld_wait_cnt", 32'(dut.ld_wait_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();

      foreach (vecs[i]) apply(vecs[i]);

      // Continuous contention: core wins four times, then the starved loader gets one slot.
      for (int i = 0; i < 6; i++) begin
         apply(mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, i == 4, i == 4));
         check("contend ld_wait_cnt", 32'(dut.ld_wait_cnt), (i < 5) ? 32'(i) : 32'd0);
      end

      // Idle: counter left at 1 by the final denial clears after one idle cycle.
      for (int i = 0; i < 10; i++) begin
         apply(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
         check("idle ld_wait_cnt", 32'(dut.ld_wait_cnt), (i == 0) ? 32'd1 : 32'd0);
      end

      // Reset arrives the cycle after a granted core read: the return must be dropped.
      apply(mk(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
      @(posedge clk); #1;
      rst = 1'b1;
      core_req = 1'b1; ld_req = 1'b1;
      exp_q.delete();
      exp_core_rdata = '0; exp_ld_rdata = '0; last_addr = '0; last_wdata = '0;
      @(negedge clk);
      check("midrst core_rvalid", 32'(core_rvalid), 32'd0);
      check("midrst ld_rvalid", 32'(ld_rvalid), 32'd0);
      check("midrst core_rdata", core_rdata, 32'd0);
      check("midrst ld_rdata", ld_rdata, 32'd0);
      check("midrst mem_addr", mem_addr, 32'd0);
      check("midrst mem_we", 32'(mem_we), 32'd0);
      check("midrst core_stall", 32'(core_stall), 32'd1);
      check("midrst ld_gnt", 32'(ld_gnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
      for (int i = 0; i < 3; i++)
         apply(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
      apply(mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
      apply(mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, maximum consecutive cycles a waiting requester is denied.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 core_req  input  1  memory-stage access request.
REQ-006 core_we  input  1  core write (1) / read (0).
REQ-007 core_addr  input  ADDR_W  core byte address.
REQ-008 core_wdata  input  32  core write data.
REQ-009 core_stall  output  1  core denied this cycle; pipeline holds.
REQ-010 core_rdata  output  32  core read data.
REQ-011 core_rvalid  output  1  core_rdata valid.
REQ-012 ld_req, ld_we, ld_addr, ld_wdata  input  1/1/ADDR_W/32  loader request, same meaning as core_*.
REQ-013 ld_gnt  output  1  loader granted this cycle.
REQ-014 ld_rdata, ld_rvalid  output  32/1  loader read data and valid.
REQ-015 mem_addr, mem_we, mem_wdata  output  ADDR_W/1/32  drive to data memory.
REQ-016 mem_rdata  input  32  data memory read data, valid 1 cycle after issue.

Function
REQ-017 SHALL grant at most one requester per cycle; granted request drives mem_* combinationally in the same cycle.
REQ-018 No request: mem_we SHALL be 0; mem_addr, mem_wdata SHALL hold last values.
REQ-019 Only one requester active: that requester SHALL be granted.
REQ-020 Both active: core SHALL win unless ld_wait_cnt == STARVE_MAX, then loader SHALL win.
REQ-021 ld_wait_cnt SHALL increment each cycle ld_req=1 and loader not granted, saturating at STARVE_MAX; SHALL clear on loader grant or ld_req=0.
REQ-022 core_stall SHALL equal core_req AND NOT core granted; ld_gnt SHALL equal loader granted.
REQ-023 Requesters SHALL hold req/we/addr/wdata stable until granted; arbiter does not latch denied requests.
REQ-024 SHALL register rd_owner (NONE/CORE/LD) each cycle a granted read issues, else NONE.
REQ-025 Cycle after a granted read: owner's rvalid SHALL be 1 and rdata SHALL equal mem_rdata; other rvalid 0.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 rdata of non-owner SHALL hold its last value.
REQ-028 Back-to-back reads from alternating owners SHALL each return correctly with no bubble.

Reset
REQ-029 On rst: rd_owner=NONE, ld_wait_cnt=0, core_rvalid=ld_rvalid=0, core_rdata=ld_rdata=0, mem_addr=mem_wdata=0, mem_we=0.
REQ-030 Read in flight when rst asserts SHALL be discarded; no rvalid after rst deasserts until a new read is granted.
REQ-031 Requests present during rst SHALL not be granted: core_stall=core_req, ld_gnt=0.

Structure
REQ-032 dmem_owner_t enum (NONE, CORE, LD) SHALL live in common_pkg.
REQ-033 Single module; no sub-module; data_memory instantiated outside and connected via mem_*.

Verification
REQ-034 Core-only read: core_req=1, core_we=0, addr 0x10, memory holds 0xDEADBEEF -> core_stall=0, next cycle core_rvalid=1, core_rdata=0xDEADBEEF.
REQ-035 Contention: both req continuous, STARVE_MAX=4 -> core granted cycles 0-3, loader granted cycle 4, core again cycle 5, ld_wait_cnt returns to 0.
REQ-036 Loader write then core read: ld write 0x20=0x12345678 granted, next cycle core reads 0x20 -> core_rdata=0x12345678, ld_rvalid stays 0.
REQ-037 Alternating reads: core reads 0x0 (0xAAAA0000), then loader reads 0x4 (0xBBBB0004) -> core_rvalid cycle N+1, ld_rvalid cycle N+2, correct data each.
REQ-038 Reset mid-read: grant core read, assert rst next cycle -> core_rvalid=0, all outputs at reset values, no rvalid after release.
REQ-039 Idle: no requests 10 cycles -> mem_we=0 throughout, no rvalid, ld_wait_cnt=0.
